// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and grant codes for mem_arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic [1:0] GNT_I = 2'b01;
   localparam logic [1:0] GNT_D = 2'b10;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - tie-break for mem_arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin
// (ptr = 1 means D won the previous grant), otherwise D has fixed priority.
module arb_select
   import mem_arb_pkg::*;
(
   input  logic       i_req,
   input  logic       d_req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         gnt = ptr ? GNT_I : GNT_D;
`else
         gnt = GNT_D;
`endif
      end else if (d_req) begin
         gnt = GNT_D;
      end else if (i_req) begin
         gnt = GNT_I;
      end
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   logic unused_ptr;
   assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D line-refill arbiter onto one memory port; tie policy set by
// MEM_ARB_ROUND_ROBIN_EN (round-robin when defined, D fixed priority otherwise).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 128
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req,
   input  logic                  d_req,
   input  logic                  i_we,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [LINE_WIDTH-1:0] i_wdata,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  i_ready,
   output logic                  d_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic [1:0]            grant
);

   localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int LINE_BITS   = ADDR_WIDTH - OFFSET_BITS;

   arb_state_t state, state_next;

   logic [1:0]            owner;
   logic [1:0]            pick;
   logic                  ptr;
   logic [LINE_BITS-1:0]  lat_line;
   logic                  lat_we;
   logic [LINE_WIDTH-1:0] lat_wdata;
   logic [LINE_WIDTH-1:0] i_rdata_q;
   logic [LINE_WIDTH-1:0] d_rdata_q;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_we;
   logic [LINE_WIDTH-1:0] sel_wdata;
   logic [OFFSET_BITS-1:0] unused_offset;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= 1'b0;
      else if (state == IDLE && (i_req || d_req))
         rr_ptr <= (pick == GNT_D);
   end

   assign ptr = rr_ptr;
`else
   assign ptr = 1'b0;
`endif

   arb_select u_select (
      .i_req (i_req),
      .d_req (d_req),
      .ptr   (ptr),
      .gnt   (pick)
   );

   always_comb begin
      sel_addr  = i_addr;
      sel_we    = i_we;
      sel_wdata = i_wdata;
      if (pick == GNT_D) begin
         sel_addr  = d_addr;
         sel_we    = d_we;
         sel_wdata = d_wdata;
      end
   end

   // Offset bits never reach memory; only the line number is latched.
   assign unused_offset = sel_addr[OFFSET_BITS-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_req || d_req) state_next = BUSY;
         BUSY:    if (mem_ready) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= 2'b00;
         lat_line  <= '0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: if (i_req || d_req) begin
               owner     <= pick;
               lat_line  <= sel_addr[ADDR_WIDTH-1:OFFSET_BITS];
               lat_we    <= sel_we;
               lat_wdata <= sel_wdata;
            end
            BUSY: if (mem_ready) begin
               if (owner == GNT_D)
                  d_rdata_q <= mem_rdata;
               else
                  i_rdata_q <= mem_rdata;
            end
            RESP:    owner <= 2'b00;
            default: owner <= 2'b00;
         endcase
      end
   end

   assign grant     = owner;
   assign mem_req   = (state == BUSY);
   assign mem_we    = mem_req && lat_we;
   assign mem_addr  = {lat_line, {OFFSET_BITS{1'b0}}};
   assign mem_wdata = lat_wdata;
   assign i_ready   = (state == RESP) && (owner == GNT_I);
   assign d_ready   = (state == RESP) && (owner == GNT_D);
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule
